// File: rtl/gray_fifo_arb_pkg.sv
// gray_fifo_arb_pkg: shared types for the gray FIFO write-port arbiter
// Contents: arb_state_e FSM states, HDR_SEQ_W header sequence width,
// hdr_word_t header layout and make_hdr builder.
package gray_fifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, HDR, XFER} arb_state_e;
  localparam int HDR_SEQ_W = 8;
  typedef struct packed {
    logic [15:0]          rsvd_hi;
    logic [HDR_SEQ_W-1:0] seq;
    logic [4:0]           rsvd_lo;
    logic [2:0]           src;
  } hdr_word_t;
  function automatic hdr_word_t make_hdr(logic [HDR_SEQ_W-1:0] seq, logic [2:0] src);
    hdr_word_t h;
    h = '0;
    h.seq = seq;
    h.src = src;
    return h;
  endfunction
endpackage

// File: rtl/gray_fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first request at or after a start pointer
// Ports: req_i request vector, ptr_i start pointer, any_o some request set, idx_o chosen index.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         any_o,
  output logic [W-1:0] idx_o
);
  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  // Low copy keeps only requests at/after ptr; the high copy supplies the wrap-around.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = (i >= int'(ptr_i));
    dbl = {req_i, req_i & mask};
    any_o = |req_i;
    idx_o = '0;
    for (int i = 2*N-1; i >= 0; i--) if (dbl[i]) idx_o = W'(i % N);
  end
endmodule

// File: rtl/gray_fifo_wr_arbiter.sv
// gray_fifo_wr_arbiter: packet-level round-robin arbiter for the write port of a gray FIFO
// Ports: clk/rst (sync, active-high); req_valid_i/req_data_i/req_last_i/req_ready_o per source;
// fifo_wvalid_o/fifo_wdata_o/fifo_wready_i/fifo_cnt_i FIFO write side;
// active_src_o granted source, busy_o packet in progress, err_oversize_o oversize pulse.
// Option: define GRAY_FIFO_ARB_HDR_EN to prefix every packet with a header word.
module gray_fifo_wr_arbiter
  import gray_fifo_arb_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int MAX_PKT   = 16,
  parameter int LOG_DEPTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC-1:0]           req_valid_i,
  input  logic [N_SRC-1:0][31:0]     req_data_i,
  input  logic [N_SRC-1:0]           req_last_i,
  output logic [N_SRC-1:0]           req_ready_o,
  output logic                       fifo_wvalid_o,
  output logic [31:0]                fifo_wdata_o,
  input  logic                       fifo_wready_i,
  input  logic [LOG_DEPTH:0]         fifo_cnt_i,
  output logic [$clog2(N_SRC)-1:0]   active_src_o,
  output logic                       busy_o,
  output logic                       err_oversize_o
);
  localparam int SW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_PKT+1);
`ifdef GRAY_FIFO_ARB_HDR_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif
  localparam logic [LOG_DEPTH:0] DEPTH = {1'b1, {LOG_DEPTH{1'b0}}};
  arb_state_e        state_q, state_d;
  logic [SW-1:0]     act_q, act_d, rr_q, rr_d, pick;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LOG_DEPTH:0] free;
  logic              admit, any, fire, last;
`ifdef GRAY_FIFO_ARB_HDR_EN
  logic [HDR_SEQ_W-1:0] seq_q, seq_d;
`endif
  assign free           = DEPTH - fifo_cnt_i;
  assign admit          = int'(free) >= MAX_PKT + HDR_WORDS;
  assign fire           = state_q == XFER && req_valid_i[act_q] && fifo_wready_i;
  assign last           = req_last_i[act_q];
  assign active_src_o   = act_q;
  assign busy_o         = state_q != IDLE;
  // Counter saturates at MAX_PKT, so the MAX_PKT-1 match happens at most once per packet.
  assign err_oversize_o = fire && !last && cnt_q == CW'(MAX_PKT-1);
  rr_pick #(.N(N_SRC)) u_pick (
    .req_i (req_valid_i),
    .ptr_i (rr_q),
    .any_o (any),
    .idx_o (pick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef GRAY_FIFO_ARB_HDR_EN
  always_ff @(posedge clk) seq_q <= rst ? '0 : seq_d;
`endif
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
`ifdef GRAY_FIFO_ARB_HDR_EN
    seq_d   = seq_q;
`endif
    case (state_q)
      IDLE: if (any && admit) begin
        act_d = pick;
`ifdef GRAY_FIFO_ARB_HDR_EN
        state_d = HDR;
`else
        state_d = XFER;
`endif
      end
`ifdef GRAY_FIFO_ARB_HDR_EN
      HDR: if (fifo_wready_i) begin
        seq_d   = seq_q + 1'b1;
        state_d = XFER;
      end
`endif
      XFER: if (fire) begin
        cnt_d = last ? '0 : (cnt_q == CW'(MAX_PKT)) ? cnt_q : cnt_q + 1'b1;
        if (last) begin
          rr_d    = (act_q == SW'(N_SRC-1)) ? '0 : act_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready_o   = '0;
    fifo_wvalid_o = 1'b0;
    fifo_wdata_o  = '0;
    if (state_q == XFER) begin
      fifo_wvalid_o      = req_valid_i[act_q];
      fifo_wdata_o       = req_data_i[act_q];
      req_ready_o[act_q] = fifo_wready_i;
    end
`ifdef GRAY_FIFO_ARB_HDR_EN
    if (state_q == HDR) begin
      fifo_wvalid_o = 1'b1;
      fifo_wdata_o  = make_hdr(seq_q, 3'(act_q));
    end
`endif
  end
endmodule

// File: tb/tb_gray_fifo_wr_arbiter.sv
// tb_gray_fifo_wr_arbiter: scoreboard bench for gray_fifo_wr_arbiter (default or GRAY_FIFO_ARB_HDR_EN build)
module tb_gray_fifo_wr_arbiter;
  localparam int N = 4, MAXP = 16, LD = 10;
`ifdef GRAY_FIFO_ARB_HDR_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid_i = '0, req_last_i = '0, req_ready_o;
  logic [N-1:0][31:0] req_data_i = '0;
  logic fifo_wvalid_o, fifo_wready_i = 1, busy_o, err_oversize_o;
  logic [31:0] fifo_wdata_o;
  logic [LD:0] fifo_cnt_i = '0;
  logic [1:0] active_src_o;
  always #5 clk = ~clk;
  gray_fifo_wr_arbiter #(.N_SRC(N), .MAX_PKT(MAXP), .LOG_DEPTH(LD)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .fifo_wvalid_o(fifo_wvalid_o),
    .fifo_wdata_o(fifo_wdata_o), .fifo_wready_i(fifo_wready_i), .fifo_cnt_i(fifo_cnt_i),
    .active_src_o(active_src_o), .busy_o(busy_o), .err_oversize_o(err_oversize_o)
  );
  int checks = 0, errors = 0;
  logic [31:0] bd[N][256];
  bit bl[N][256];
  int nb[N], pos[N];
  logic [32:0] exq[$];
  logic [32:0] me;
  int seq_m, ptr_m, err_seen;
  bit bub, rw, rc;
  logic wr_fix;
  logic [N-1:0] s_acc, s_ready;
  logic s_busy, s_wv, s_err;
  logic [31:0] s_wd;
  logic [1:0] s_act;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic add_pkt(int s, int len, int pk);
    for (int b = 0; b < len; b++) begin
      bd[s][nb[s]] = {4'(s), 4'(pk), 24'($urandom)};
      bl[s][nb[s]] = (b == len-1);
      nb[s]++;
    end
  endtask
  // Expected FIFO stream: serve whole packets round-robin among sources with packets pending.
  task automatic build_expect();
    int cur[N];
    int s, b;
    for (int i = 0; i < N; i++) cur[i] = pos[i];
    do begin
      s = -1;
      for (int k = N-1; k >= 0; k--) if (cur[(ptr_m+k)%N] < nb[(ptr_m+k)%N]) s = (ptr_m+k)%N;
      if (s >= 0) begin
        if (H == 1) begin
          exq.push_back({1'b0, 16'h0, 8'(seq_m), 5'h0, 3'(s)});
          seq_m = (seq_m + 1) % 256;
        end
        b = 0;
        do begin
          exq.push_back({(b == MAXP-1 && !bl[s][cur[s]]), bd[s][cur[s]]});
          b++;
          cur[s]++;
        end while (!bl[s][cur[s]-1]);
        ptr_m = (s + 1) % N;
      end
    end while (s >= 0);
  endtask
  task automatic apply();
    for (int s = 0; s < N; s++) begin
      if (pos[s] < nb[s]) begin
        req_valid_i[s] = !(bub && pos[s] > 0 && !bl[s][pos[s]-1] && $urandom_range(0, 2) == 0);
        req_data_i[s]  = bd[s][pos[s]];
        req_last_i[s]  = bl[s][pos[s]];
      end else begin
        req_valid_i[s] = 0;
        req_data_i[s]  = '0;
        req_last_i[s]  = 0;
      end
    end
    fifo_wready_i = rw ? ($urandom_range(0, 3) != 0) : wr_fix;
    if (rc) fifo_cnt_i = ($urandom_range(0, 3) == 0) ? 11'd1010 : 11'($urandom_range(0, 900));
  endtask
  task automatic tick();
    @(negedge clk);
    s_acc = req_valid_i & req_ready_o;
    s_busy = busy_o; s_ready = req_ready_o; s_wv = fifo_wvalid_o;
    s_wd = fifo_wdata_o; s_act = active_src_o; s_err = err_oversize_o;
    for (int s = 0; s < N; s++) if (s_acc[s]) pos[s]++;
    @(posedge clk);
    #1;
    apply();
  endtask
  function automatic bit all_done();
    for (int s = 0; s < N; s++) if (pos[s] < nb[s]) return 0;
    return 1;
  endfunction
  task automatic drain(string nm, int budget);
    int n = 0;
    while ((!all_done() || exq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({nm, " drain_left"}, 32'(exq.size()), 0);
    chk({nm, " src_done"}, 32'(all_done()), 1);
  endtask
  task automatic do_reset();
    rst = 1; bub = 0; rw = 0; rc = 0; wr_fix = 1; fifo_cnt_i = '0;
    for (int s = 0; s < N; s++) begin nb[s] = 0; pos[s] = 0; end
    exq.delete();
    seq_m = 0; ptr_m = 0;
    apply();
    tick();
    tick();
    rst = 0;
  endtask
  task automatic chk_idle_outs(string nm);
    chk({nm, " ready"}, 32'(s_ready), 0);
    chk({nm, " wvalid"}, 32'(s_wv), 0);
    chk({nm, " wdata"}, s_wd, 0);
    chk({nm, " active"}, 32'(s_act), 0);
    chk({nm, " busy"}, 32'(s_busy), 0);
    chk({nm, " err"}, 32'(s_err), 0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (err_oversize_o) err_seen++;
      chk("ready_onehot", 32'($countones(req_ready_o) <= 1), 1);
      if (fifo_wvalid_o && fifo_wready_i) begin
        if (exq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got %h expected none", fifo_wdata_o);
        end else begin
          me = exq.pop_front();
          chk("wdata", fifo_wdata_o, me[31:0]);
          chk("oversize", 32'(err_oversize_o), 32'(me[32]));
        end
      end else chk("err_no_write", 32'(err_oversize_o), 0);
    end
  end
  initial begin
    int n;
    bub = 0; rw = 0; rc = 0; wr_fix = 1; err_seen = 0;
    do_reset();
    chk_idle_outs("reset");
    add_pkt(2, 3, 0); build_expect(); apply();
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t1 accept", 32'(s_acc[2]), 32'(c >= 1+H && c <= 3+H));
      chk("t1 busy", 32'(s_busy), 32'(c >= 1 && c <= 3+H));
      if (c == 0) chk("t1 ready_decision", 32'(s_ready), 0);
    end
    chk("t1 drained", 32'(exq.size()), 0);
    do_reset();
    for (int s = 0; s < N; s++) for (int p = 0; p < 3; p++) add_pkt(s, 2, p);
    build_expect(); apply();
    drain("t2", 200);
    do_reset();
    fifo_cnt_i = 11'(1009 - H);
    add_pkt(0, 2, 0); build_expect(); apply();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t3 no_grant busy", 32'(s_busy), 0);
      chk("t3 no_grant acc", 32'(s_acc), 0);
    end
    fifo_cnt_i = 11'(1008 - H);
    tick();
    chk("t3 decide busy", 32'(s_busy), 0);
    tick();
    chk("t3 granted busy", 32'(s_busy), 1);
    drain("t3", 50);
    fifo_cnt_i = '0;
    add_pkt(1, 8, 1); build_expect(); apply();
    n = 0;
    while (pos[1] < 3 && n < 20) begin tick(); n++; end
    chk("t4 reach_beat3", 32'(pos[1]), 3);
    wr_fix = 0; apply();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4 ready_low", 32'(s_ready[1]), 0);
      chk("t4 no_accept", 32'(s_acc), 0);
    end
    wr_fix = 1; apply();
    tick();
    chk("t4 ready_back", 32'(s_ready[1]), 1);
    drain("t4", 50);
    err_seen = 0;
    add_pkt(3, 20, 2); build_expect(); apply();
    drain("t5", 100);
    chk("t5 err_pulses", 32'(err_seen), 1);
    do_reset();
    add_pkt(1, 2, 0); build_expect(); apply();
    drain("t6a", 50);
    add_pkt(2, 4, 1); build_expect(); apply();
    n = 0;
    while (pos[2] < 1 && n < 20) begin tick(); n++; end
    chk("t6 reach_beat2", 32'(pos[2]), 1);
    do_reset();
    chk_idle_outs("t6 mid_reset");
    add_pkt(3, 2, 2); add_pkt(0, 2, 2); build_expect(); apply();
    drain("t6b", 50);
    do_reset();
    for (int s = 0; s < N; s++) for (int p = 0; p < 4; p++) add_pkt(s, $urandom_range(1, 20), p);
    build_expect();
    bub = 1; rw = 1; rc = 1;
    apply();
    drain("t7", 6000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
